// File: rtl/crc16_r.sv
// Receive-side CRC16 checker: strips PID and trailing CRC bytes from DATA packets,
// forwards the payload through a single output register and reports per-packet status.
module crc16_r #(
    parameter int unsigned LEN_W     = 10,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF,
    parameter logic [15:0] CRC_POLY  = 16'hA001,
    parameter logic [15:0] CRC_RESID = 16'hB001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_sop,
    input  logic             rx_eop,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             pl_sop,
    output logic             pl_eop,
    output logic             pl_valid,
    output logic [7:0]       pl_data,
    input  logic             pl_ready,
    output logic [3:0]       data_pid,
    output logic             rx_done,
    output logic             crc16_err,
    output logic [LEN_W-1:0] rx_len
);

    typedef enum logic [1:0] {StIdle, StSkip, StData} state_e;

    state_e           state_q, state_d;
    logic [15:0]      crc_q, crc_d, crc_upd;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    logic             first_q, first_d;
    logic [7:0]       h0_q, h0_d, h1_q, h1_d;
    logic             h0_v_q, h0_v_d, h1_v_q, h1_v_d;
    logic             pl_valid_q, pl_valid_d;
    logic             pl_sop_q, pl_sop_d;
    logic             pl_eop_q, pl_eop_d;
    logic [7:0]       pl_data_q, pl_data_d;
    logic [3:0]       pid_q, pid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] rx_len_q, rx_len_d;
    logic             accept;
    logic             pid_ok;
    logic             take_sop;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) r = r ^ CRC_POLY;
        end
        return r;
    endfunction

    assign rx_ready = !pl_valid_q || pl_ready;

    always_comb begin
        accept   = rx_valid && rx_ready;
        pid_ok   = (rx_data[7:4] == ~rx_data[3:0]) && (rx_data[1:0] == 2'b11);
        crc_upd  = crc_byte(crc_q, rx_data);
        len_inc  = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
        // SKIP ignores sop; it only leaves on eop
        take_sop = accept && rx_sop && (state_q != StSkip);

        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        first_d    = first_q;
        h0_d       = h0_q;
        h0_v_d     = h0_v_q;
        h1_d       = h1_q;
        h1_v_d     = h1_v_q;
        pl_valid_d = pl_valid_q;
        pl_sop_d   = pl_sop_q;
        pl_eop_d   = pl_eop_q;
        pl_data_d  = pl_data_q;
        pid_d      = pid_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rx_len_d   = rx_len_q;

        if (pl_valid_q && pl_ready) pl_valid_d = 1'b0;

        if (take_sop) begin
            if (state_q == StData) err_d = 1'b1;
            h0_v_d = 1'b0;
            h1_v_d = 1'b0;
            if (rx_eop) begin
                state_d = StIdle;
            end else if (pid_ok) begin
                state_d = StData;
                pid_d   = rx_data[3:0];
                crc_d   = CRC_INIT;
                len_d   = '0;
                first_d = 1'b1;
            end else begin
                state_d = StSkip;
            end
        end else if (accept) begin
            case (state_q)
                StSkip: begin
                    if (rx_eop) state_d = StIdle;
                end
                StData: begin
                    // Two-byte holdback: h1 is only released once it cannot be a CRC byte
                    if (h1_v_q) begin
                        pl_valid_d = 1'b1;
                        pl_data_d  = h1_q;
                        pl_sop_d   = first_q;
                        pl_eop_d   = rx_eop;
                        first_d    = 1'b0;
                        len_d      = len_inc;
                    end
                    if (rx_eop) begin
                        done_d   = 1'b1;
                        rx_len_d = h1_v_q ? len_inc : len_q;
                        err_d    = (crc_upd != CRC_RESID) || !h0_v_q;
                        h0_v_d   = 1'b0;
                        h1_v_d   = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        crc_d  = crc_upd;
                        h1_d   = h0_q;
                        h1_v_d = h0_v_q;
                        h0_d   = rx_data;
                        h0_v_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            crc_q      <= CRC_INIT;
            len_q      <= '0;
            first_q    <= 1'b0;
            h0_q       <= '0;
            h0_v_q     <= 1'b0;
            h1_q       <= '0;
            h1_v_q     <= 1'b0;
            pl_valid_q <= 1'b0;
            pl_sop_q   <= 1'b0;
            pl_eop_q   <= 1'b0;
            pl_data_q  <= '0;
            pid_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rx_len_q   <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            first_q    <= first_d;
            h0_q       <= h0_d;
            h0_v_q     <= h0_v_d;
            h1_q       <= h1_d;
            h1_v_q     <= h1_v_d;
            pl_valid_q <= pl_valid_d;
            pl_sop_q   <= pl_sop_d;
            pl_eop_q   <= pl_eop_d;
            pl_data_q  <= pl_data_d;
            pid_q      <= pid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rx_len_q   <= rx_len_d;
        end
    end

    assign pl_valid  = pl_valid_q;
    assign pl_sop    = pl_sop_q;
    assign pl_eop    = pl_eop_q;
    assign pl_data   = pl_data_q;
    assign data_pid  = pid_q;
    assign rx_done   = done_q;
    assign crc16_err = err_q;
    assign rx_len    = rx_len_q;

endmodule

// File: tb/tb_crc16_r.sv
// Bench for crc16_r: table of packet vectors, hand-written corner sequences and random
// packets, all checked against a packet-level reference model and scoreboard.
module tb_crc16_r;

    localparam int LEN_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx_sop, rx_eop, rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ready;
    logic             pl_sop, pl_eop, pl_valid;
    logic [7:0]       pl_data;
    logic             pl_ready = 1'b1;
    logic [3:0]       data_pid;
    logic             rx_done, crc16_err;
    logic [LEN_W-1:0] rx_len;

    always #5 clk = ~clk;

    crc16_r #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst),
        .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready),
        .pl_sop(pl_sop), .pl_eop(pl_eop), .pl_valid(pl_valid), .pl_data(pl_data),
        .pl_ready(pl_ready),
        .data_pid(data_pid), .rx_done(rx_done), .crc16_err(crc16_err), .rx_len(rx_len)
    );

    typedef logic [7:0] byte_q_t [$];
    typedef struct packed { logic [7:0] d; logic s; logic e; } beat_t;
    typedef struct { bit done; bit err; int len; logic [3:0] pid; } stat_t;
    typedef struct {
        logic [7:0] pid; int npl; int ncrc; bit flip;
        int e_beats; int e_done; int e_err; int e_len;
    } vec_t;

    beat_t  exp_beats[$];
    stat_t  exp_stat[$];
    int     errors = 0;
    int     checks = 0;
    int     obs_beats, obs_done, obs_err, obs_len;
    bit     mon_en = 1'b0;
    bit     gaps = 1'b0;
    int     rdy_mode = 0;
    beat_t  b_exp;
    stat_t  s_exp;
    logic   stall_q = 1'b0;
    logic [9:0] hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [15:0] crc_of(input byte_q_t q);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ q[i][b]) c = (c >> 1) ^ 16'hA001;
                else                c = c >> 1;
            end
        end
        return c;
    endfunction

    function automatic byte_q_t make_pkt(input logic [7:0] pid, input int npl, input int ncrc,
                                         input bit flip);
        byte_q_t     q;
        byte_q_t     pl;
        logic [15:0] c;
        for (int i = 0; i < npl; i++) pl.push_back(8'($urandom));
        c = ~crc_of(pl);
        q.push_back(pid);
        foreach (pl[i]) q.push_back(pl[i]);
        if (ncrc > 0) q.push_back(c[7:0]);
        if (ncrc > 1) q.push_back(c[15:8]);
        if (flip && npl > 1) q[2] = q[2] ^ 8'h10;
        return q;
    endfunction

    // Expected payload beats and status for one packet as sent on the rx side
    function automatic void model(input byte_q_t q, input bit complete);
        int          n;
        int          npl;
        bit          good;
        byte_q_t     pl;
        logic [15:0] c;
        logic [7:0]  p;
        n = q.size() - 1;
        p = q[0];
        if (!((p[7:4] == ~p[3:0]) && (p[1:0] == 2'b11))) return;
        if (complete && n == 0) return;
        npl = (n >= 2) ? n - 2 : 0;
        for (int i = 1; i <= npl; i++) begin
            pl.push_back(q[i]);
            exp_beats.push_back('{d: q[i], s: (i == 1), e: (complete && i == npl)});
        end
        if (complete) begin
            c = ~crc_of(pl);
            good = (n >= 2) && (q[n-1] == c[7:0]) && (q[n] == c[15:8]);
            exp_stat.push_back('{done: 1'b1, err: !good, len: npl, pid: p[3:0]});
        end else begin
            exp_stat.push_back('{done: 1'b0, err: 1'b1, len: 0, pid: 4'h0});
        end
    endfunction

    always @(negedge clk) begin
        case (rdy_mode)
            0:       pl_ready = 1'b1;
            1:       pl_ready = ($urandom_range(3) != 0);
            default: pl_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            if (stall_q) check("stall_hold", {pl_valid, pl_data, pl_sop, pl_eop}, {1'b1, hold});
            if (pl_valid && !pl_ready) check("stall_rx_ready", rx_ready, 0);
            stall_q = pl_valid && !pl_ready;
            hold    = {pl_data, pl_sop, pl_eop};
            if (pl_valid && pl_ready) begin
                obs_beats++;
                if (exp_beats.size() == 0) fail_now("beat_unexpected");
                else begin
                    b_exp = exp_beats.pop_front();
                    check("beat", {pl_data, pl_sop, pl_eop}, b_exp);
                end
            end
            if (rx_done || crc16_err) begin
                if (rx_done) begin
                    obs_done++;
                    obs_len = int'(rx_len);
                end
                if (crc16_err) obs_err++;
                if (exp_stat.size() == 0) fail_now("status_unexpected");
                else begin
                    s_exp = exp_stat.pop_front();
                    check("status_flags", {rx_done, crc16_err}, {s_exp.done, s_exp.err});
                    if (s_exp.done) begin
                        check("status_len", rx_len, s_exp.len);
                        check("status_pid", data_pid, s_exp.pid);
                    end
                end
            end
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic drive_byte(input logic [7:0] d, input bit s, input bit e);
        int waited;
        waited = 0;
        @(negedge clk);
        while (gaps && $urandom_range(3) == 0) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_sop   = s;
        rx_eop   = e;
        #1;
        while (!rx_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!rx_ready) fail_now("rx_ready_timeout");
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic send_pkt(input byte_q_t q, input bit complete);
        foreach (q[i]) drive_byte(q[i], i == 0, complete && (i == q.size() - 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_stat.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_beats.size() != 0 || exp_stat.size() != 0) begin
            fail_now("drain_timeout");
            exp_beats.delete();
            exp_stat.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    vec_t       tbl[11];
    byte_q_t    q, p, tr;
    logic [7:0] pids[8];
    bit         complete;
    int         k;

    initial begin
        tbl[0]  = '{8'hC3, 0, 2, 1'b0, 0, 1, 0, 0};
        tbl[1]  = '{8'h4B, 4, 2, 1'b0, 4, 1, 0, 4};
        tbl[2]  = '{8'h4B, 4, 2, 1'b1, 4, 1, 1, 4};
        tbl[3]  = '{8'hE1, 0, 2, 1'b0, 0, 0, 0, 0};
        tbl[4]  = '{8'hD2, 0, 0, 1'b0, 0, 0, 0, 0};
        tbl[5]  = '{8'hC2, 4, 2, 1'b0, 0, 0, 0, 0};
        tbl[6]  = '{8'h4B, 0, 1, 1'b0, 0, 1, 1, 0};
        tbl[7]  = '{8'h87, 1, 2, 1'b0, 1, 1, 0, 1};
        tbl[8]  = '{8'h0F, 17, 2, 1'b0, 17, 1, 0, 17};
        tbl[9]  = '{8'h69, 0, 2, 1'b0, 0, 0, 0, 0};
        tbl[10] = '{8'hC3, 3, 2, 1'b1, 3, 1, 1, 3};
        pids    = '{8'hC3, 8'h4B, 8'h87, 8'h0F, 8'hE1, 8'hD2, 8'h69, 8'hA5};

        rst = 1'b1; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              {pl_valid, pl_sop, pl_eop, pl_data, data_pid, rx_done, crc16_err, rx_len}, 0);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Zero-length DATA0: status one cycle after eop
        q = make_pkt(8'hC3, 0, 2, 1'b0);
        model(q, 1'b1);
        send_pkt(q, 1'b1);
        @(negedge clk);
        #1;
        check("t1_status", {rx_done, crc16_err, rx_len, data_pid}, {1'b1, 1'b0, 10'd0, 4'h3});
        drain();

        // DATA1 with 4 bytes: last beat and status both one cycle after eop
        q = make_pkt(8'h4B, 4, 2, 1'b0);
        model(q, 1'b1);
        send_pkt(q, 1'b1);
        @(negedge clk);
        #1;
        check("t2_last_beat", {pl_valid, pl_eop, rx_done, pl_data}, {3'b111, q[4]});
        drain();

        gaps = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 11; i++) begin
            obs_beats = 0; obs_done = 0; obs_err = 0; obs_len = 0;
            q = make_pkt(tbl[i].pid, tbl[i].npl, tbl[i].ncrc, tbl[i].flip);
            model(q, 1'b1);
            send_pkt(q, 1'b1);
            drain();
            check($sformatf("vec%0d_beats", i), obs_beats, tbl[i].e_beats);
            check($sformatf("vec%0d_done", i), obs_done, tbl[i].e_done);
            check($sformatf("vec%0d_err", i), obs_err, tbl[i].e_err);
            check($sformatf("vec%0d_len", i), obs_len, tbl[i].e_len);
        end

        // Five-cycle pl_ready stall in the middle of a packet
        gaps = 1'b0;
        rdy_mode = 0;
        q = make_pkt(8'h4B, 10, 2, 1'b0);
        model(q, 1'b1);
        fork
            send_pkt(q, 1'b1);
            begin
                repeat (5) @(negedge clk);
                #2 rdy_mode = 2;
                repeat (3) @(negedge clk);
                #1 check("t5_stalled", {pl_valid, rx_ready}, 2'b10);
                repeat (2) @(negedge clk);
                #2 rdy_mode = 0;
            end
        join
        drain();

        // Abort: new sop after PID+3 bytes, then a good packet
        q = make_pkt(8'h4B, 5, 2, 1'b0);
        tr = q;
        while (tr.size() > 4) tr.pop_back();
        p = make_pkt(8'hC3, 2, 2, 1'b0);
        model(tr, 1'b0);
        model(p, 1'b1);
        send_pkt(tr, 1'b0);
        drive_byte(p[0], 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("t6_abort", {crc16_err, rx_done}, 2'b10);
        for (int i = 1; i < p.size(); i++) drive_byte(p[i], 1'b0, i == p.size() - 1);
        drain();

        // Reset in the middle of a packet
        q = make_pkt(8'h4B, 4, 2, 1'b0);
        for (int i = 0; i < 4; i++) drive_byte(q[i], i == 0, 1'b0);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_reset_outputs",
              {pl_valid, pl_sop, pl_eop, pl_data, data_pid, rx_done, crc16_err, rx_len}, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_beats.delete();
        exp_stat.delete();
        mon_en = 1'b1;
        q = make_pkt(8'hC3, 3, 2, 1'b0);
        model(q, 1'b1);
        send_pkt(q, 1'b1);
        drain();

        // Random packets, including truncated DATA packets that the next sop aborts
        gaps = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(7);
            q = make_pkt(pids[k], (k == 5) ? 0 : $urandom_range(12), (k == 5) ? 0 : 2,
                         $urandom_range(3) == 0);
            complete = 1'b1;
            if (i != 39 && k < 4 && $urandom_range(7) == 0) begin
                complete = 1'b0;
                k = $urandom_range(q.size() - 1);
                while (q.size() > k + 1) q.pop_back();
            end
            model(q, complete);
            send_pkt(q, complete);
        end
        drain();
        check("queues_empty", exp_beats.size() + exp_stat.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
